// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing of one FPU adder between two requesters
// Latches the winner's operands, pulses add, waits for idle or timeout, then routes the result.
module fpu_arbiter #(
  parameter int EXP_W   = 7,
  parameter int MAN_W   = 15,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [EXP_W-1:0] req0_ae,
  input  logic [EXP_W-1:0] req0_be,
  input  logic [MAN_W-1:0] req0_am,
  input  logic [MAN_W-1:0] req0_bm,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [EXP_W-1:0] req1_ae,
  input  logic [EXP_W-1:0] req1_be,
  input  logic [MAN_W-1:0] req1_am,
  input  logic [MAN_W-1:0] req1_bm,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp0_err,
  output logic [EXP_W-1:0] rsp0_e,
  output logic [MAN_W-1:0] rsp0_m,
  output logic             rsp1_valid,
  output logic             rsp1_err,
  output logic [EXP_W-1:0] rsp1_e,
  output logic [MAN_W-1:0] rsp1_m,
  output logic             fpu_add,
  output logic [EXP_W-1:0] fpu_r1e,
  output logic [EXP_W-1:0] fpu_r2e,
  output logic [MAN_W-1:0] fpu_r1m,
  output logic [MAN_W-1:0] fpu_r2m,
  input  logic [EXP_W-1:0] fpu_rse,
  input  logic [MAN_W-1:0] fpu_rsm,
  input  logic             fpu_idle,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             req0_ready_q, req0_ready_d, req1_ready_q, req1_ready_d;
  logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic             rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
  logic [EXP_W-1:0] rsp0_e_q, rsp0_e_d, rsp1_e_q, rsp1_e_d;
  logic [MAN_W-1:0] rsp0_m_q, rsp0_m_d, rsp1_m_q, rsp1_m_d;
  logic             fpu_add_q, fpu_add_d;
  logic [EXP_W-1:0] r1e_q, r1e_d, r2e_q, r2e_d;
  logic [MAN_W-1:0] r1m_q, r1m_d, r2m_q, r2m_d;
  logic             busy_q, busy_d;

  logic             win;
  logic             done;
  logic             res_err;
  logic [EXP_W-1:0] res_e;
  logic [MAN_W-1:0] res_m;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_err_d   = rsp0_err_q;
    rsp1_err_d   = rsp1_err_q;
    rsp0_e_d     = rsp0_e_q;
    rsp0_m_d     = rsp0_m_q;
    rsp1_e_d     = rsp1_e_q;
    rsp1_m_d     = rsp1_m_q;
    fpu_add_d    = 1'b0;
    r1e_d        = r1e_q;
    r1m_d        = r1m_q;
    r2e_d        = r2e_q;
    r2m_d        = r2m_q;
    win          = 1'b0;
    done         = 1'b0;
    res_err      = 1'b0;
    res_e        = '0;
    res_m        = '0;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the port that did not win last time goes first.
          win          = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          r1e_d        = win ? req1_ae : req0_ae;
          r1m_d        = win ? req1_am : req0_am;
          r2e_d        = win ? req1_be : req0_be;
          r2m_d        = win ? req1_bm : req0_bm;
          req0_ready_d = ~win;
          req1_ready_d = win;
          grant_d      = win;
          last_grant_d = win;
          fpu_add_d    = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (fpu_idle) begin
          done  = 1'b1;
          res_e = fpu_rse;
          res_m = fpu_rsm;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          done    = 1'b1;
          res_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done) begin
          state_d = S_RESP;
          if (grant_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_err_d   = res_err;
            rsp1_e_d     = res_e;
            rsp1_m_d     = res_m;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_err_d   = res_err;
            rsp0_e_d     = res_e;
            rsp0_m_d     = res_m;
          end
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp0_e_q     <= '0;
      rsp0_m_q     <= '0;
      rsp1_e_q     <= '0;
      rsp1_m_q     <= '0;
      fpu_add_q    <= 1'b0;
      r1e_q        <= '0;
      r1m_q        <= '0;
      r2e_q        <= '0;
      r2m_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req0_ready_q <= req0_ready_d;
      req1_ready_q <= req1_ready_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp0_e_q     <= rsp0_e_d;
      rsp0_m_q     <= rsp0_m_d;
      rsp1_e_q     <= rsp1_e_d;
      rsp1_m_q     <= rsp1_m_d;
      fpu_add_q    <= fpu_add_d;
      r1e_q        <= r1e_d;
      r1m_q        <= r1m_d;
      r2e_q        <= r2e_d;
      r2m_q        <= r2m_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_err   = rsp1_err_q;
  assign rsp0_e     = rsp0_e_q;
  assign rsp0_m     = rsp0_m_q;
  assign rsp1_e     = rsp1_e_q;
  assign rsp1_m     = rsp1_m_q;
  assign fpu_add    = fpu_add_q;
  assign fpu_r1e    = r1e_q;
  assign fpu_r1m    = r1m_q;
  assign fpu_r2e    = r2e_q;
  assign fpu_r2m    = r2m_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - directed bench for fpu_arbiter with a behavioural FPU
// Cycle numbers are counted from the cycle in which a request is first sampled.
module tb_fpu_arbiter;
  localparam int EW = 7;
  localparam int MW = 15;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req1_valid;
  logic [EW-1:0] req0_ae, req0_be, req1_ae, req1_be;
  logic [MW-1:0] req0_am, req0_bm, req1_am, req1_bm;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [EW-1:0] rsp0_e, rsp1_e;
  logic [MW-1:0] rsp0_m, rsp1_m;
  logic          fpu_add;
  logic [EW-1:0] fpu_r1e, fpu_r2e;
  logic [MW-1:0] fpu_r1m, fpu_r2m;
  logic [EW-1:0] fpu_rse = '0;
  logic [MW-1:0] fpu_rsm = '0;
  logic          fpu_idle = 1'b1;
  logic          busy;

  fpu_arbiter #(.EXP_W(EW), .MAN_W(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ae(req0_ae), .req0_be(req0_be),
    .req0_am(req0_am), .req0_bm(req0_bm), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_ae(req1_ae), .req1_be(req1_be),
    .req1_am(req1_am), .req1_bm(req1_bm), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_e(rsp0_e), .rsp0_m(rsp0_m),
    .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_e(rsp1_e), .rsp1_m(rsp1_m),
    .fpu_add(fpu_add), .fpu_r1e(fpu_r1e), .fpu_r2e(fpu_r2e),
    .fpu_r1m(fpu_r1m), .fpu_r2m(fpu_r2m),
    .fpu_rse(fpu_rse), .fpu_rsm(fpu_rsm), .fpu_idle(fpu_idle), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FPU: drops idle on add, raises it with the model result fdelay cycles later.
  int            fcnt = 0;
  int            fdelay = 6;
  bit            hang = 1'b0;
  logic [EW-1:0] model_e = '0;
  logic [MW-1:0] model_m = '0;
  always @(negedge clk) begin
    if (fpu_add) begin
      fcnt = fdelay;
      fpu_idle = 1'b0;
    end else if (!hang && fcnt > 0) begin
      fcnt--;
      if (fcnt == 0) begin
        fpu_idle = 1'b1;
        fpu_rse = model_e;
        fpu_rsm = model_m;
      end
    end
  end

  logic [2*EW+2*MW-1:0] ops, cur_ops = '0;
  assign ops = {fpu_r1e, fpu_r1m, fpu_r2e, fpu_r2m};

  int            n_add = 0;
  int            stab_viol = 0;
  int            n_rdy[2] = '{0, 0};
  int            n_rsp[2] = '{0, 0};
  int            rdy_cyc[2] = '{0, 0};
  int            rsp_cyc[2] = '{0, 0};
  logic [EW-1:0] rsp_e_s[2];
  logic [MW-1:0] rsp_m_s[2];
  logic          rsp_err_s[2];
  int            g_log[$];

  always @(negedge clk) begin
    if (fpu_add) n_add++;
    if (req0_ready) begin n_rdy[0]++; rdy_cyc[0] = cyc; g_log.push_back(0); cur_ops = ops; end
    if (req1_ready) begin n_rdy[1]++; rdy_cyc[1] = cyc; g_log.push_back(1); cur_ops = ops; end
    if (busy && !req0_ready && !req1_ready && ops != cur_ops) stab_viol++;
    if (rsp0_valid) begin
      n_rsp[0]++; rsp_cyc[0] = cyc;
      rsp_e_s[0] = rsp0_e; rsp_m_s[0] = rsp0_m; rsp_err_s[0] = rsp0_err;
    end
    if (rsp1_valid) begin
      n_rsp[1]++; rsp_cyc[1] = cyc;
      rsp_e_s[1] = rsp1_e; rsp_m_s[1] = rsp1_m; rsp_err_s[1] = rsp1_err;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [EW-1:0] ae, input logic [MW-1:0] am,
                         input logic [EW-1:0] be, input logic [MW-1:0] bm);
    if (p == 0) begin
      req0_ae = ae; req0_am = am; req0_be = be; req0_bm = bm; req0_valid = 1'b1;
    end else begin
      req1_ae = ae; req1_am = am; req1_be = be; req1_bm = bm; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_ready(input int p, input bit drop);
    int start;
    int b;
    start = n_rdy[p];
    b = 0;
    while (n_rdy[p] == start && b < 60) begin tick(); b++; end
    check((p == 0) ? "ready0_seen" : "ready1_seen", 64'(n_rdy[p] != start), 1);
    if (drop) begin
      if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int p);
    int start;
    int b;
    start = n_rsp[p];
    b = 0;
    while (n_rsp[p] == start && b < 60) begin tick(); b++; end
    check((p == 0) ? "rsp0_seen" : "rsp1_seen", 64'(n_rsp[p] != start), 1);
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy && b < 100) begin tick(); b++; end
    check("idle_reached", busy, 0);
  endtask

  localparam logic [2*EW+2*MW-1:0] OPS_T1 = {7'h41, 15'h4000, 7'h40, 15'h6000};
  localparam logic [2*EW+2*MW-1:0] OPS_A  = {7'h11, 15'h0aaa, 7'h12, 15'h0bbb};
  localparam logic [2*EW+2*MW-1:0] OPS_B  = {7'h21, 15'h1ccc, 7'h22, 15'h1ddd};
  localparam logic [2*EW+2*MW-1:0] OPS_C  = {7'h35, 15'h2345, 7'h36, 15'h3456};

  int t0, g, a0, sv, r0, r1;

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ae = '0; req0_am = '0; req0_be = '0; req0_bm = '0;
    req1_ae = '0; req1_am = '0; req1_be = '0; req1_bm = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_add", fpu_add, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
    check("rst_ops", ops, 0);
    check("rst_res", {rsp0_e, rsp0_m, rsp1_e, rsp1_m}, 0);
    rst_n = 1'b1;
    tick();

    // Single request on port 0.
    model_e = 7'h42; model_m = 15'h5000;
    t0 = cyc;
    set_req(0, 7'h41, 15'h4000, 7'h40, 15'h6000);
    wait_ready(0, 1);
    check("t1_ready_cyc", rdy_cyc[0], t0 + 1);
    check("t1_add_now", fpu_add, 1);
    check("t1_ops", ops, OPS_T1);
    check("t1_busy", busy, 1);
    wait_rsp(0);
    check("t1_rsp_cyc", rsp_cyc[0], t0 + 8);
    check("t1_rsp", {rsp_err_s[0], rsp_e_s[0], rsp_m_s[0]}, {1'b0, 7'h42, 15'h5000});
    check("t1_adds", n_add, 1);
    check("t1_no_rsp1", n_rsp[1], 0);
    repeat (3) tick();
    check("t1_hold", {rsp0_e, rsp0_m}, {7'h42, 15'h5000});
    check("t1_idle", busy, 0);

    // Simultaneous requests straight out of reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    g = g_log.size(); a0 = n_add;
    model_e = 7'h10; model_m = 15'h0123;
    t0 = cyc;
    set_req(0, 7'h11, 15'h0aaa, 7'h12, 15'h0bbb);
    set_req(1, 7'h21, 15'h1ccc, 7'h22, 15'h1ddd);
    wait_ready(0, 1);
    check("t2_first_cyc", rdy_cyc[0], t0 + 1);
    check("t2_ops0", ops, OPS_A);
    wait_ready(1, 1);
    check("t2_second_cyc", rdy_cyc[1], t0 + 10);
    check("t2_ops1", ops, OPS_B);
    wait_rsp(1);
    check("t2_rsp1", {rsp_err_s[1], rsp_e_s[1], rsp_m_s[1]}, {1'b0, 7'h10, 15'h0123});
    check("t2_order0", (g < g_log.size()) ? g_log[g] : -1, 0);
    check("t2_order1", (g + 1 < g_log.size()) ? g_log[g + 1] : -1, 1);
    check("t2_adds", n_add - a0, 2);
    wait_idle();

    // Fairness: port 0 held, port 1 re-requesting after each grant.
    g = g_log.size();
    set_req(0, 7'h11, 15'h0aaa, 7'h12, 15'h0bbb);
    set_req(1, 7'h21, 15'h1ccc, 7'h22, 15'h1ddd);
    for (int b = 0; b < 300 && g_log.size() < g + 4; b++) begin
      tick();
      if (req1_ready) req1_valid = 1'b0;
      else if (!req1_valid) req1_valid = 1'b1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t3_ngrants", g_log.size() - g, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_grant%0d", i), (g + i < g_log.size()) ? g_log[g + i] : -1, i % 2);
    wait_idle();

    // Operand stability while the requester changes its inputs.
    sv = stab_viol;
    model_e = 7'h55; model_m = 15'h7777;
    set_req(1, 7'h35, 15'h2345, 7'h36, 15'h3456);
    wait_ready(1, 1);
    req1_ae = 7'h7f; req1_am = 15'h7fff; req1_be = 7'h00; req1_bm = 15'h0001;
    repeat (4) tick();
    check("t4_ops_wait", ops, OPS_C);
    wait_rsp(1);
    check("t4_ops_resp", ops, OPS_C);
    check("t4_stable", stab_viol - sv, 0);
    check("t4_rsp1", {rsp_err_s[1], rsp_e_s[1], rsp_m_s[1]}, {1'b0, 7'h55, 15'h7777});
    wait_idle();

    // Timeout with a hung FPU, then a normal request.
    hang = 1'b1;
    t0 = cyc;
    set_req(0, 7'h01, 15'h0002, 7'h03, 15'h0004);
    wait_ready(0, 1);
    wait_rsp(0);
    check("t5_to_cyc", rsp_cyc[0], t0 + 4 + TO + 1);
    check("t5_to_rsp", {rsp_err_s[0], rsp_e_s[0], rsp_m_s[0]}, {1'b1, 7'h00, 15'h0000});
    hang = 1'b0;
    wait_idle();
    model_e = 7'h33; model_m = 15'h1abc;
    t0 = cyc;
    set_req(0, 7'h05, 15'h0006, 7'h07, 15'h0008);
    wait_ready(0, 1);
    wait_rsp(0);
    check("t5_after_cyc", rsp_cyc[0], t0 + 8);
    check("t5_after_rsp", {rsp_err_s[0], rsp_e_s[0], rsp_m_s[0]}, {1'b0, 7'h33, 15'h1abc});
    wait_idle();

    // Reset in the middle of WAIT.
    hang = 1'b1;
    r0 = n_rsp[0]; r1 = n_rsp[1];
    set_req(1, 7'h35, 15'h2345, 7'h36, 15'h3456);
    wait_ready(1, 1);
    repeat (4) tick();
    check("t6_in_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ops", ops, 0);
    check("t6_rst_res", {rsp0_e, rsp0_m, rsp1_e, rsp1_m}, 0);
    check("t6_rst_flags", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, fpu_add}, 0);
    tick(); tick();
    rst_n = 1'b1;
    hang = 1'b0;
    repeat (20) tick();
    check("t6_no_rsp0", n_rsp[0], r0);
    check("t6_no_rsp1", n_rsp[1], r1);
    g = g_log.size();
    set_req(0, 7'h11, 15'h0aaa, 7'h12, 15'h0bbb);
    set_req(1, 7'h21, 15'h1ccc, 7'h22, 15'h1ddd);
    wait_ready(0, 1);
    wait_ready(1, 1);
    wait_rsp(1);
    check("t6_order0", (g < g_log.size()) ? g_log[g] : -1, 0);
    check("t6_order1", (g + 1 < g_log.size()) ? g_log[g + 1] : -1, 1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares the single `fpu` instance between two independent requesters (port 0: the UART command controller; port 1: a second host/sequencer) with round-robin arbitration. It latches operands, pulses `add`, holds the operands stable while the FPU works, detects completion from `idle`, and routes the result and a completion pulse back to the winning port. A timeout guards against a hung FPU.

## Interface
- `EXP_W`, default 7: exponent width.
- `MAN_W`, default 15: mantissa width.
- `TIMEOUT`, default 255: maximum cycles in WAIT before the operation is aborted with an error.
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): request. Must be held, with stable operands, until `reqN_ready`.
- `reqN_ae`, `reqN_be` in EXP_W: operand A and B exponents.
- `reqN_am`, `reqN_bm` in MAN_W: operand A and B mantissas.
- `reqN_ready` out 1: one-cycle accept pulse.
- `rspN_valid` out 1: one-cycle completion pulse.
- `rspN_err` out 1: timeout flag. Qualified by `rspN_valid`.
- `rspN_e` out EXP_W, `rspN_m` out MAN_W: result. Held until the next response to the same port.
- `fpu_add` out 1: one-cycle start pulse to the FPU.
- `fpu_r1e`, `fpu_r2e` out EXP_W; `fpu_r1m`, `fpu_r2m` out MAN_W: registered operands to the FPU.
- `fpu_rse` in EXP_W, `fpu_rsm` in MAN_W: FPU result.
- `fpu_idle` in 1: FPU idle/done.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, SETTLE, WAIT, RESP.
- **IDLE**
  - If any `reqN_valid` is high, grant one port. A single requester wins. If both are high, the port not granted last time (`last_grant`) wins.
  - Latch the winner's operands into `fpu_r1e/r1m` (A) and `fpu_r2e/r2m` (B). Operands pass unmodified; there is no width conversion.
  - Set `reqN_ready` for one cycle, record `grant` and `last_grant`, and go to ISSUE.
- **ISSUE**: `fpu_add`=1 for exactly this cycle, then go to SETTLE.
- **SETTLE**: 2 cycles; `fpu_idle` is ignored. Then go to WAIT.
- **WAIT**
  - The timeout counter increments each cycle.
  - If `fpu_idle`=1: capture `fpu_rse/rsm` into the granted port's result registers, set `err`=0, and go to RESP.
  - If the counter reaches TIMEOUT first: set the result to 0, set `err`=1, and go to RESP.
  - The `fpu_idle` check has priority over the timeout in the same cycle.
- **RESP**
  - `rspN_valid`=1 for the granted port only, for one cycle. `rspN_err` is driven at the same time.
  - Return to IDLE. The counter clears.
- `fpu_r*` hold their values outside IDLE-grant, so operands are stable for the entire operation.
- Requests arriving while busy wait; no queueing beyond the held valid.
- Dropping `reqN_valid` before ready is a protocol violation. If the port is not yet granted, it is simply not serviced.
- `last_grant` toggles only on a grant. When a single requester is present, it always wins regardless of `last_grant`.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the top level) clears:
  - state to IDLE, `last_grant`=1 (port 0 wins the first tie);
  - all `reqN_ready`, `rspN_valid`, `rspN_err`, `fpu_add`, `busy` to 0;
  - all `rspN_e/m` and `fpu_r*` to 0; the counter to 0.
- Reset mid-operation aborts the operation. No response is issued for it.
- Cycle numbering for a request:
  - Cycle 0: valid is sampled in IDLE.
  - Cycle 1: `reqN_ready`=1 and `fpu_add`=1; operands are on `fpu_r*`; `busy`=1.
  - Cycles 2–3: SETTLE.
  - Cycle 4 onward: WAIT.
  - `fpu_idle` sampled high at cycle k gives `rspN_valid` at cycle k+1.
  - Cycle k+2: IDLE; a new request can be sampled here.
- Minimum latency from valid to `rsp_valid` is 5 cycles.
- Timeout: `rsp_valid` with `err`=1 arrives at cycle 4+TIMEOUT+1 when `fpu_idle` stays 0.
- Back-to-back tie: after a response, the other waiting port is granted at the next IDLE cycle.

## Test plan
- **Single request:**
  - Stimulus: port 0, ae=7'h41, am=15'h4000, be=7'h40, bm=15'h6000; FPU model returns rse=7'h42, rsm=15'h5000 after 6 cycles.
  - Required: `ready0` at cycle 1, exactly one `fpu_add` pulse, `rsp0_valid` with 42/5000 and err=0, `rsp1_valid` never high.
- **Simultaneous requests from reset:**
  - Stimulus: both ports valid with different operands.
  - Required: port 0 is served first, then port 1; the `fpu_r*` values match each port; two `fpu_add` pulses in total.
- **Fairness:** port 0 holds valid continuously and port 1 requests repeatedly. Required: grants alternate 0,1,0,1; neither port starves.
- **Operand stability:** requester changes its inputs after `ready`. Required: `fpu_r*` stay unchanged until RESP.
- **Timeout:** `fpu_idle` is held at 0 with TIMEOUT=8. Required: `rsp0_valid` with err=1 and e/m=0 at cycle 13; the block then returns to IDLE and serves a normal request afterwards.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT. Required: all outputs are 0 immediately; no `rsp_valid` is issued; the next request after release is served with port 0 priority.
